pr_free_list_alloc: RTL and testbench

Physical-register allocator that sequences the register file's lifecycle: it hands out free PRs to SICs and drives the RF allocate/reset ports. It reclaims released PRs only once the RF reports them idle. It sits between the Issue Controller/SICs and register_file and is the sole source of the RF's alloc_wen/alloc_pr.

---
 rtl/pr_free_list_alloc_pkg.sv | 17 +
 rtl/pr_free_list_alloc_if.sv | 26 ++
 rtl/pr_reclaim_picker.sv | 20 ++
 rtl/pr_free_list_alloc.sv | 126 ++++++++++++
 tb/tb_pr_free_list_alloc.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/pr_free_list_alloc_pkg.sv
// Shared sizing and index types for the physical-register free list.
// NUM_ARCH_REGS is also used by register_file: PRs below it are never allocatable.
package pr_free_list_alloc_pkg;
  localparam int NUM_PHY_REGS  = 64;
  localparam int NUM_SICS      = 2;
  localparam int NUM_ARCH_REGS = 32;
  localparam int FIFO_DEPTH    = NUM_PHY_REGS - NUM_ARCH_REGS;
  localparam int PR_W          = $clog2(NUM_PHY_REGS);
  localparam int CNT_W         = PR_W + 1;
  localparam int PTR_W         = $clog2(FIFO_DEPTH);
  localparam int SIC_W         = (NUM_SICS > 1) ? $clog2(NUM_SICS) : 1;

  typedef logic [PR_W-1:0]  pr_idx_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [SIC_W-1:0] sic_t;
endpackage

// File: rtl/pr_free_list_alloc_if.sv
// Allocation, release and register_file sideband bundle of the PR free list.
// master = SIC/issue side driving requests; slave = the allocator.
interface pr_free_list_alloc_if;
  import pr_free_list_alloc_pkg::*;

  logic [NUM_SICS-1:0]     alloc_req;
  logic [NUM_SICS-1:0]     alloc_gnt;
  pr_idx_t                 alloc_pr [NUM_SICS];
  logic [NUM_SICS-1:0]     rf_alloc_wen;
  pr_idx_t                 rf_alloc_pr [NUM_SICS];
  logic [NUM_SICS-1:0]     free_req;
  pr_idx_t                 free_pr [NUM_SICS];
  logic [NUM_PHY_REGS-1:0] pr_not_idle;
  cnt_t                    free_count;
  cnt_t                    pending_count;

  modport master (
    output alloc_req, free_req, free_pr, pr_not_idle,
    input  alloc_gnt, alloc_pr, rf_alloc_wen, rf_alloc_pr, free_count, pending_count
  );

  modport slave (
    input  alloc_req, free_req, free_pr, pr_not_idle,
    output alloc_gnt, alloc_pr, rf_alloc_wen, rf_alloc_pr, free_count, pending_count
  );
endinterface

// File: rtl/pr_reclaim_picker.sv
// Lowest-index priority encoder over reclaimable PRs; purely combinational.
module pr_reclaim_picker #(
  parameter int N = 64,
  parameter int W = 6
) (
  input  logic [N-1:0] cand,
  output logic         vld,
  output logic [W-1:0] idx
);
  always_comb begin
    vld = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        vld = 1'b1;
        idx = i[W-1:0];
      end
    end
  end
endmodule

// File: rtl/pr_free_list_alloc.sv
// PR free list: zero-latency round-robin grants from a circular FIFO, one reclaim per cycle
// once register_file reports a released PR idle. Denied requesters hold req; rr_ptr moves to them.
module pr_free_list_alloc
  import pr_free_list_alloc_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  pr_free_list_alloc_if.slave bus
);
  pr_idx_t                 fifo_mem [FIFO_DEPTH];
  ptr_t                    head, tail;
  cnt_t                    free_cnt, pend_cnt, n_gnt, n_free;
  logic [NUM_PHY_REGS-1:0] pending, in_fifo;
  sic_t                    rr_ptr, deny_idx;
  logic                    deny_vld, push, chk_armed;
  pr_idx_t                 push_pr;
  logic [NUM_SICS-1:0]     gnt, free_ok;
  pr_idx_t                 gnt_pr [NUM_SICS];

  // Gated by rst_n so no grant escapes while reset is asserted.
  always_comb begin : grant
    int unsigned tmp;
    sic_t        s;
    tmp      = 0;
    s        = '0;
    n_gnt    = '0;
    gnt      = '0;
    deny_vld = 1'b0;
    deny_idx = '0;
    for (int k = 0; k < NUM_SICS; k++) gnt_pr[k] = '0;
    for (int k = 0; k < NUM_SICS; k++) begin
      tmp = int'(rr_ptr) + k;
      s   = sic_t'(tmp % NUM_SICS);
      if (bus.alloc_req[s] && rst_n) begin
        if (n_gnt < free_cnt) begin
          gnt[s]    = 1'b1;
          gnt_pr[s] = fifo_mem[head + ptr_t'(n_gnt)];
          n_gnt     = n_gnt + cnt_t'(1);
        end else if (!deny_vld) begin
          deny_vld = 1'b1;
          deny_idx = s;
        end
      end
    end
  end

  // Illegal releases are dropped; a same-cycle duplicate keeps only the lower port.
  always_comb begin : free_check
    free_ok = '0;
    n_free  = '0;
    for (int s = 0; s < NUM_SICS; s++) begin
      free_ok[s] = bus.free_req[s] && (bus.free_pr[s] >= pr_idx_t'(NUM_ARCH_REGS)) &&
                   !pending[bus.free_pr[s]] && !in_fifo[bus.free_pr[s]];
      for (int t = 0; t < s; t++) begin
        if (bus.free_req[t] && bus.free_pr[t] == bus.free_pr[s]) free_ok[s] = 1'b0;
      end
      n_free = n_free + cnt_t'(free_ok[s]);
    end
  end

  pr_reclaim_picker #(.N(NUM_PHY_REGS), .W(PR_W)) u_reclaim_picker (
    .cand (pending & ~bus.pr_not_idle),
    .vld  (push),
    .idx  (push_pr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= pr_idx_t'(NUM_ARCH_REGS + i);
      head      <= '0;
      tail      <= '0;
      free_cnt  <= cnt_t'(FIFO_DEPTH);
      pend_cnt  <= '0;
      pending   <= '0;
      in_fifo   <= {{FIFO_DEPTH{1'b1}}, {NUM_ARCH_REGS{1'b0}}};
      rr_ptr    <= '0;
      chk_armed <= 1'b0;
    end else begin
      chk_armed <= 1'b1;
      head      <= head + ptr_t'(n_gnt);
      free_cnt  <= free_cnt - n_gnt + cnt_t'(push);
      pend_cnt  <= pend_cnt + n_free - cnt_t'(push);
      if (deny_vld) rr_ptr <= deny_idx;
      for (int s = 0; s < NUM_SICS; s++) begin
        if (gnt[s]) in_fifo[gnt_pr[s]] <= 1'b0;
      end
      if (push) begin
        fifo_mem[tail]   <= push_pr;
        tail             <= tail + ptr_t'(1);
        in_fifo[push_pr] <= 1'b1;
        pending[push_pr] <= 1'b0;
      end
      for (int s = 0; s < NUM_SICS; s++) begin
        if (free_ok[s]) pending[bus.free_pr[s]] <= 1'b1;
      end
    end
  end

  assign bus.alloc_gnt     = gnt;
  assign bus.rf_alloc_wen  = gnt;
  assign bus.free_count    = free_cnt;
  assign bus.pending_count = pend_cnt;
  for (genvar g = 0; g < NUM_SICS; g++) begin : g_out
    assign bus.alloc_pr[g]    = gnt_pr[g];
    assign bus.rf_alloc_pr[g] = gnt_pr[g];
  end

  always @(posedge clk) begin
    if (rst_n) begin
      for (int s = 0; s < NUM_SICS; s++) begin
        assert (!bus.free_req[s] || free_ok[s])
          else $fatal(1, "FAIL illegal release port %0d pr %0d", s, bus.free_pr[s]);
      end
      assert (!(push && (free_cnt - n_gnt) == cnt_t'(FIFO_DEPTH)))
        else $fatal(1, "FAIL free list overflow");
    end
    if (rst_n && chk_armed) begin
      assert (!$isunknown(bus.alloc_req) && !$isunknown(bus.free_req))
        else $fatal(1, "FAIL unknown value on alloc_req/free_req");
      for (int s = 0; s < NUM_SICS; s++) begin
        assert (!bus.free_req[s] || !$isunknown(bus.free_pr[s]))
          else $fatal(1, "FAIL unknown free_pr on port %0d", s);
      end
    end
  end
endmodule

// File: tb/tb_pr_free_list_alloc.sv
// Directed + random bench for pr_free_list_alloc against a queue-based model of the free list.
module tb_pr_free_list_alloc;
  import pr_free_list_alloc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  pr_free_list_alloc_if bus ();
  pr_free_list_alloc dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: FIFO of free PRs, released-not-reclaimed set, round-robin start.
  pr_idx_t m_q [$];
  bit      m_pend [NUM_PHY_REGS];
  int      m_rr;
  pr_idx_t live [$];
  bit      is_live [NUM_PHY_REGS];
  logic    last_gnt [NUM_SICS];
  logic [31:0] last_pr [NUM_SICS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int i = NUM_ARCH_REGS; i < NUM_PHY_REGS; i++) m_q.push_back(pr_idx_t'(i));
    for (int i = 0; i < NUM_PHY_REGS; i++) begin
      m_pend[i]  = 1'b0;
      is_live[i] = 1'b0;
    end
    live.delete();
    m_rr = 0;
  endtask

  task automatic do_free(input int port, input pr_idx_t p);
    for (int i = 0; i < live.size(); i++) begin
      if (live[i] == p) begin
        live.delete(i);
        break;
      end
    end
    is_live[p]          = 1'b0;
    bus.free_req[port]  = 1'b1;
    bus.free_pr[port]   = p;
  endtask

  // One clock: check outputs at negedge, advance the model at posedge, clear releases.
  task automatic cycle();
    bit                      e_gnt [NUM_SICS];
    pr_idx_t                 e_pr [NUM_SICS];
    logic [NUM_PHY_REGS-1:0] ni;
    logic [NUM_SICS-1:0]     fq;
    pr_idx_t                 fp [NUM_SICS];
    int ng, first_den, s, pc, rp;
    @(negedge clk);
    ng = 0;
    first_den = -1;
    for (int k = 0; k < NUM_SICS; k++) begin
      e_gnt[k] = 1'b0;
      e_pr[k]  = '0;
    end
    for (int k = 0; k < NUM_SICS; k++) begin
      s = (m_rr + k) % NUM_SICS;
      if (bus.alloc_req[s]) begin
        if (ng < m_q.size()) begin
          e_gnt[s] = 1'b1;
          e_pr[s]  = m_q[ng];
          ng++;
        end else if (first_den < 0) begin
          first_den = s;
        end
      end
    end
    pc = 0;
    for (int i = 0; i < NUM_PHY_REGS; i++) pc += int'(m_pend[i]);
    for (int k = 0; k < NUM_SICS; k++) begin
      chk($sformatf("gnt%0d", k), bus.alloc_gnt[k], e_gnt[k]);
      chk($sformatf("pr%0d", k), bus.alloc_pr[k], e_pr[k]);
      chk($sformatf("rf_wen%0d", k), bus.rf_alloc_wen[k], e_gnt[k]);
      chk($sformatf("rf_pr%0d", k), bus.rf_alloc_pr[k], e_pr[k]);
      if (bus.alloc_gnt[k] === 1'b1) chk($sformatf("nodup%0d", k), is_live[bus.alloc_pr[k]], 0);
      last_gnt[k] = bus.alloc_gnt[k];
      last_pr[k]  = 32'(bus.alloc_pr[k]);
    end
    chk("free_count", bus.free_count, m_q.size());
    chk("pending_count", bus.pending_count, pc);
    ni = bus.pr_not_idle;
    fq = bus.free_req;
    for (int k = 0; k < NUM_SICS; k++) fp[k] = bus.free_pr[k];
    @(posedge clk);
    for (int k = 0; k < ng; k++) void'(m_q.pop_front());
    for (int k = 0; k < NUM_SICS; k++) begin
      if (e_gnt[k]) begin
        is_live[e_pr[k]] = 1'b1;
        live.push_back(e_pr[k]);
      end
    end
    rp = -1;
    for (int p = 0; p < NUM_PHY_REGS; p++) begin
      if (m_pend[p] && !ni[p]) begin
        rp = p;
        break;
      end
    end
    if (rp >= 0) begin
      m_q.push_back(pr_idx_t'(rp));
      m_pend[rp] = 1'b0;
    end
    for (int k = 0; k < NUM_SICS; k++) if (fq[k]) m_pend[fp[k]] = 1'b1;
    if (first_den >= 0) m_rr = first_den;
    #1;
    bus.free_req = '0;
  endtask

  initial begin
    bus.alloc_req   = '1;
    bus.free_req    = '0;
    bus.pr_not_idle = '0;
    for (int k = 0; k < NUM_SICS; k++) bus.free_pr[k] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", bus.alloc_gnt, 0);
    chk("rst_wen", bus.rf_alloc_wen, 0);
    chk("rst_free_count", bus.free_count, 32);
    bus.alloc_req = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    cycle();
    bus.alloc_req = 2'b01;
    cycle();
    chk("first_pr", last_pr[0], 32);
    bus.alloc_req = 2'b00;
    cycle();
    bus.alloc_req = 2'b11;
    cycle();
    chk("pair_pr1", last_pr[1], 34);

    while (m_q.size() > 1) begin
      bus.alloc_req = (m_q.size() >= 3) ? 2'b11 : 2'b01;
      cycle();
    end
    bus.alloc_req = 2'b11;
    cycle();
    chk("last_pr0", last_pr[0], 63);
    chk("deny_gnt1", last_gnt[1], 0);
    cycle();
    bus.alloc_req = 2'b10;
    do_free(0, pr_idx_t'(40));
    cycle();
    cycle();
    cycle();
    chk("recl_gnt1", last_gnt[1], 1);
    chk("recl_pr1", last_pr[1], 40);

    bus.alloc_req = 2'b00;
    bus.pr_not_idle[45] = 1'b1;
    do_free(0, pr_idx_t'(45));
    repeat (6) cycle();
    bus.pr_not_idle[45] = 1'b0;
    repeat (2) cycle();

    for (int c = 0; c < 200; c++) begin
      int idx;
      bus.alloc_req = 2'($urandom_range(0, 3));
      for (int k = 0; k < NUM_SICS; k++) begin
        if (live.size() > 0 && $urandom_range(0, 99) < 45) begin
          idx = $urandom_range(0, live.size() - 1);
          do_free(k, live[idx]);
        end
      end
      bus.pr_not_idle = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      cycle();
    end

    bus.pr_not_idle = '0;
    bus.alloc_req   = 2'b11;
    for (int i = 0; i < 40 && live.size() < 3; i++) cycle();
    bus.pr_not_idle = '1;
    do_free(0, live[0]);
    do_free(1, live[0]);
    cycle();
    do_free(0, live[0]);
    cycle();
    cycle();
    chk("pre_rst_pending", bus.pending_count, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", bus.alloc_gnt, 0);
    chk("mid_rst_wen", bus.rf_alloc_wen, 0);
    chk("mid_rst_pr0", bus.alloc_pr[0], 0);
    chk("mid_rst_free_count", bus.free_count, 32);
    chk("mid_rst_pending", bus.pending_count, 0);
    model_reset();
    bus.pr_not_idle = '0;
    bus.alloc_req   = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    bus.alloc_req = 2'b01;
    cycle();
    chk("post_rst_pr", last_pr[0], 32);
    bus.alloc_req = 2'b00;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
